wb_arbiter: RTL and testbench
=============================

// Module: wb_arbiter
// PURPOSE
//  Write-back stage feeding the register file's single write port (rd_wren/rd_addr/rd_data).
//  Merges single-cycle ALU results with long-latency LSU load results.
//  Load data is extended and buffered in a FIFO; ALU results are never stalled.
//  Publishes a per-register pending mask for the hazard unit.
// PARAMETERS
//  DEPTH  4  LSU result FIFO entries; power of 2, >= 2
// PORTS
//  i_clk          in   1   clock; all state on rising edge
//  i_rst_n        in   1   synchronous active-low reset
//  i_alu_wren     in   1   ALU result valid this cycle (no backpressure)
//  i_alu_rd_addr  in   5   ALU destination register
//  i_alu_rd_data  in   32  ALU result
//  i_lsu_valid    in   1   load result valid
//  o_lsu_ready    out  1   FIFO can accept; transfer = valid & ready
//  i_lsu_rd_addr  in   5   load destination register
//  i_lsu_funct3   in   3   000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
//  i_lsu_offset   in   2   byte offset of load address
//  i_lsu_rdata    in   32  raw aligned memory word
//  o_rd_wren      out  1   register-file write enable
//  o_rd_addr      out  5   register-file write address
//  o_rd_data      out  32  register-file write data
//  o_busy_mask    out  32  bit r = write to x[r] still pending here
// BEHAVIOUR
//  Reset (i_rst_n=0 at edge): FIFO emptied, pointers/count 0; o_rd_wren=0,
//   o_rd_addr=0, o_rd_data=0, o_busy_mask=0; o_lsu_ready=0 while i_rst_n=0. Mid-operation
//   reset discards all buffered results.
//  Extension, applied at push: LB/LBU select byte offset[1:0]; LH/LHU select halfword
//   offset[1] (offset[0] ignored); LW passes word. LB/LH sign-extend, LBU/LHU zero-extend.
//   Other funct3 -> data 0.
//  o_lsu_ready = !full (combinational from count); never accepts when full.
//  Output register loaded every cycle, priority:
//   1) i_alu_wren & rd!=0 -> ALU result
//   2) else FIFO non-empty -> pop head
//   3) else LSU transfer this cycle & rd!=0 -> bypass FIFO straight to output
//   4) else o_rd_wren=0 (addr/data hold)
//  Bypass (3) does not push. LSU transfer not taking (3) pushes, incl. same-cycle pop (2).
//  Latency: ALU in cycle N -> o_rd_wren in N+1; regfile updates at end of N+1.
//   LSU with empty FIFO and no ALU write: same 1 cycle. Otherwise waits for ALU-idle cycles.
//  rd=0: ALU wren ignored; LSU accepted (consumes handshake) but never pushed/written.
//   o_rd_wren=1 never occurs with o_rd_addr=0.
//  LSU results retire in acceptance order. ALU-vs-LSU ordering to same rd is ensured
//   upstream via o_busy_mask; this block does not reorder or compare.
//  o_busy_mask combinational: OR of one-hot(rd) over valid FIFO entries and over output
//   register when o_rd_wren=1.
//  Pointers wrap modulo DEPTH; count 0..DEPTH; full=count==DEPTH, empty=count==0.
//  ALU writing every cycle starves the FIFO indefinitely; by design (pipeline bounds it).
// TESTING
//  Reset: assert i_rst_n=0 with FIFO holding 2 entries -> next cycle o_rd_wren=0,
//   o_busy_mask=0, o_lsu_ready=0; after release o_lsu_ready=1, old entries never written.
//  Bypass: idle, LSU LW x5, rdata=0xDEADBEEF -> next cycle wren=1, addr=5, data=0xDEADBEEF.
//  Extension: rdata=0x80FF7F01; LB off=3 -> 0xFFFFFF80; LBU off=1 -> 0x0000007F;
//   LH off=2 -> 0xFFFF80FF; LHU off=0 -> 0x00007F01.
//  Collision: same cycle ALU x3=0x11 and LSU LW x4=0x22 -> cycle+1 x3=0x11,
//   cycle+2 x4=0x22; busy_mask bit4 set in cycle+1, bit3 set in cycle+1.
//  Full: ALU writes x1 for 6 cycles while LSU offers x8..x13 -> ready drops after
//   4 accepts; then x8..x11 written in order on consecutive cycles, x12/x13 follow.
//  x0: ALU wren to x0 and LSU to x0 -> no o_rd_wren, LSU handshake still completes.

Source files
------------

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges unstalled ALU results with extended load results buffered
// in a small FIFO, drives the single register-file write port and a pending-write mask.
module wb_arbiter #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_alu_wren,
    input  logic [4:0]  i_alu_rd_addr,
    input  logic [31:0] i_alu_rd_data,
    input  logic        i_lsu_valid,
    output logic        o_lsu_ready,
    input  logic [4:0]  i_lsu_rd_addr,
    input  logic [2:0]  i_lsu_funct3,
    input  logic [1:0]  i_lsu_offset,
    input  logic [31:0] i_lsu_rdata,
    output logic        o_rd_wren,
    output logic [4:0]  o_rd_addr,
    output logic [31:0] o_rd_data,
    output logic [31:0] o_busy_mask
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [4:0]    fifo_addr_q [DEPTH];
    logic [31:0]   fifo_data_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic          wren_q, wren_d;
    logic [4:0]    addr_q, addr_d;
    logic [31:0]   data_q, data_d;

    logic          full, empty;
    logic          lsu_xfer, lsu_live, alu_live;
    logic          push, pop, bypass;
    logic [7:0]    lsu_byte;
    logic [15:0]   lsu_half;
    logic [31:0]   lsu_ext;
    logic [31:0]   busy_mask;

    assign full        = (count_q == CW'(DEPTH));
    assign empty       = (count_q == '0);
    assign o_lsu_ready = i_rst_n && !full;
    assign lsu_xfer    = i_lsu_valid && o_lsu_ready;
    assign lsu_live    = lsu_xfer && (i_lsu_rd_addr != 5'd0);
    assign alu_live    = i_alu_wren && (i_alu_rd_addr != 5'd0);

    // Buffered entries drain ahead of a fresh load, so bypass is only legal when empty.
    assign pop    = !alu_live && !empty;
    assign bypass = !alu_live && empty && lsu_live;
    assign push   = lsu_live && !bypass;

    always_comb begin
        lsu_byte = i_lsu_rdata[{i_lsu_offset, 3'b000} +: 8];
        lsu_half = i_lsu_offset[1] ? i_lsu_rdata[31:16] : i_lsu_rdata[15:0];
        case (i_lsu_funct3)
            3'b000:  lsu_ext = {{24{lsu_byte[7]}}, lsu_byte};
            3'b001:  lsu_ext = {{16{lsu_half[15]}}, lsu_half};
            3'b010:  lsu_ext = i_lsu_rdata;
            3'b100:  lsu_ext = {24'd0, lsu_byte};
            3'b101:  lsu_ext = {16'd0, lsu_half};
            default: lsu_ext = '0;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        wren_d   = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (alu_live) begin
            wren_d = 1'b1;
            addr_d = i_alu_rd_addr;
            data_d = i_alu_rd_data;
        end else if (pop) begin
            wren_d = 1'b1;
            addr_d = fifo_addr_q[rd_ptr_q];
            data_d = fifo_data_q[rd_ptr_q];
        end else if (bypass) begin
            wren_d = 1'b1;
            addr_d = i_lsu_rd_addr;
            data_d = lsu_ext;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            wren_q   <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            wren_q   <= wren_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
        end
    end

    // Storage needs no reset: occupancy is tracked solely by count_q.
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= i_lsu_rd_addr;
            fifo_data_q[wr_ptr_q] <= lsu_ext;
        end
    end

    always_comb begin
        busy_mask = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if ({1'b0, PW'(PW'(i) - rd_ptr_q)} < count_q)
                busy_mask[fifo_addr_q[i]] = 1'b1;
        end
        if (wren_q) busy_mask[addr_q] = 1'b1;
    end

    assign o_busy_mask = busy_mask;
    assign o_rd_wren   = wren_q;
    assign o_rd_addr   = addr_q;
    assign o_rd_data   = data_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus random traffic, all checked against a
// queue-based reference model of the write-back rules.
module tb_wb_arbiter;

    localparam int unsigned DEPTH = 4;

    typedef struct {
        logic [4:0]  addr;
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [31:0] rdata;
    } src_t;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_wren;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_addr;
    logic [2:0]  lsu_f3;
    logic [1:0]  lsu_off;
    logic [31:0] lsu_rdata;
    logic        rd_wren;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [31:0] busy_mask;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned n_acc = 0;

    src_t        src[$];
    ent_t        mq[$];
    logic [4:0]  wlog[$];
    logic        lsu_en;
    logic        m_wren = 1'b0;
    logic [4:0]  m_addr = '0;
    logic [31:0] m_data = '0;

    always #5 clk = ~clk;

    wb_arbiter #(.DEPTH(DEPTH)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_alu_wren    (alu_wren),
        .i_alu_rd_addr (alu_addr),
        .i_alu_rd_data (alu_data),
        .i_lsu_valid   (lsu_valid),
        .o_lsu_ready   (lsu_ready),
        .i_lsu_rd_addr (lsu_addr),
        .i_lsu_funct3  (lsu_f3),
        .i_lsu_offset  (lsu_off),
        .i_lsu_rdata   (lsu_rdata),
        .o_rd_wren     (rd_wren),
        .o_rd_addr     (rd_addr),
        .o_rd_data     (rd_data),
        .o_busy_mask   (busy_mask)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_ext(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * (off / 2))) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
            3'b001:  return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            3'b010:  return w;
            3'b100:  return b;
            3'b101:  return h;
            default: return 32'd0;
        endcase
    endfunction

    // One clock: present inputs, check ready, advance model, check registered outputs.
    task automatic step();
        logic        exp_ready, xfer, lsu_live, alu_live;
        logic [31:0] exp_mask;
        ent_t        e;
        lsu_valid = lsu_en && (src.size() > 0);
        if (src.size() > 0) begin
            lsu_addr  = src[0].addr;
            lsu_f3    = src[0].f3;
            lsu_off   = src[0].off;
            lsu_rdata = src[0].rdata;
        end
        #1;
        exp_ready = rst_n && (mq.size() < DEPTH);
        check("ready", {31'd0, lsu_ready}, {31'd0, exp_ready});
        xfer     = lsu_valid && exp_ready;
        lsu_live = xfer && (lsu_addr != 5'd0);
        alu_live = alu_wren && (alu_addr != 5'd0);
        e.addr   = lsu_addr;
        e.data   = ref_ext(lsu_f3, lsu_off, lsu_rdata);
        if (!rst_n) begin
            mq.delete();
            m_wren = 1'b0; m_addr = '0; m_data = '0;
        end else if (alu_live) begin
            m_wren = 1'b1; m_addr = alu_addr; m_data = alu_data;
            if (lsu_live) mq.push_back(e);
        end else if (mq.size() > 0) begin
            ent_t h;
            h = mq.pop_front();
            m_wren = 1'b1; m_addr = h.addr; m_data = h.data;
            if (lsu_live) mq.push_back(e);
        end else if (lsu_live) begin
            m_wren = 1'b1; m_addr = e.addr; m_data = e.data;
        end else begin
            m_wren = 1'b0;
        end
        @(posedge clk);
        #1;
        exp_mask = '0;
        foreach (mq[i]) exp_mask = exp_mask | (32'd1 << mq[i].addr);
        if (m_wren) exp_mask = exp_mask | (32'd1 << m_addr);
        check("wren", {31'd0, rd_wren}, {31'd0, m_wren});
        check("addr", {27'd0, rd_addr}, {27'd0, m_addr});
        check("data", rd_data, m_data);
        check("busy", busy_mask, exp_mask);
        if (xfer) begin
            void'(src.pop_front());
            n_acc++;
        end
        if (rd_wren) wlog.push_back(rd_addr);
    endtask

    task automatic idle();
        alu_wren = 1'b0;
        lsu_en   = 1'b0;
        step();
    endtask

    task automatic offer(input logic [4:0] a, input logic [2:0] f, input logic [1:0] o,
                         input logic [31:0] d);
        src_t s;
        s.addr = a; s.f3 = f; s.off = o; s.rdata = d;
        src.push_back(s);
    endtask

    initial begin
        logic [31:0] ext_exp [4];
        logic [2:0]  ext_f3  [4];
        logic [1:0]  ext_off [4];
        logic        stale;
        int unsigned acc0;

        rst_n = 1'b0; alu_wren = 1'b0; alu_addr = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_addr = '0; lsu_f3 = '0; lsu_off = '0; lsu_rdata = '0;
        lsu_en = 1'b0;
        @(posedge clk); #1;
        step(); step();
        check("rst_busy", busy_mask, 32'd0);
        rst_n = 1'b1;
        idle();

        // Bypass path
        offer(5'd5, 3'b010, 2'd0, 32'hDEAD_BEEF);
        lsu_en = 1'b1;
        step();
        check("byp_wren", {31'd0, rd_wren}, 32'd1);
        check("byp_addr", {27'd0, rd_addr}, 32'd5);
        check("byp_data", rd_data, 32'hDEAD_BEEF);
        idle();

        // Extension cases
        ext_f3  = '{3'b000, 3'b100, 3'b001, 3'b101};
        ext_off = '{2'd3, 2'd1, 2'd2, 2'd0};
        ext_exp = '{32'hFFFF_FF80, 32'h0000_007F, 32'hFFFF_80FF, 32'h0000_7F01};
        for (int i = 0; i < 4; i++) begin
            offer(5'd9, ext_f3[i], ext_off[i], 32'h80FF_7F01);
            lsu_en = 1'b1;
            step();
            check("ext", rd_data, ext_exp[i]);
            idle();
        end

        // ALU/LSU collision
        offer(5'd4, 3'b010, 2'd0, 32'h22);
        alu_wren = 1'b1; alu_addr = 5'd3; alu_data = 32'h11; lsu_en = 1'b1;
        step();
        check("col1_addr", {27'd0, rd_addr}, 32'd3);
        check("col1_data", rd_data, 32'h11);
        check("col1_mask", busy_mask & 32'h18, 32'h18);
        alu_wren = 1'b0; lsu_en = 1'b0;
        step();
        check("col2_addr", {27'd0, rd_addr}, 32'd4);
        check("col2_data", rd_data, 32'h22);
        idle();

        // FIFO full under continuous ALU traffic
        for (int a = 8; a <= 13; a++) offer(5'(a), 3'b010, 2'd0, 32'(a));
        acc0 = n_acc;
        alu_wren = 1'b1; alu_addr = 5'd1; alu_data = 32'h1234; lsu_en = 1'b1;
        for (int i = 0; i < 6; i++) step();
        check("full_accepts", n_acc - acc0, 32'd4);
        alu_wren = 1'b0;
        wlog.delete();
        for (int i = 0; i < 8; i++) step();
        check("full_nwr", wlog.size(), 32'd6);
        for (int i = 0; i < 6 && i < wlog.size(); i++)
            check("full_order", {27'd0, wlog[i]}, 32'(8 + i));
        lsu_en = 1'b0;
        idle();

        // x0 writes suppressed, handshake still consumed
        offer(5'd0, 3'b010, 2'd0, 32'h5555);
        alu_wren = 1'b1; alu_addr = 5'd0; alu_data = 32'h77; lsu_en = 1'b1;
        step();
        check("x0_wren", {31'd0, rd_wren}, 32'd0);
        check("x0_src", src.size(), 32'd0);
        idle();

        // Mid-operation reset with two buffered entries
        offer(5'd6, 3'b010, 2'd0, 32'h66);
        offer(5'd7, 3'b010, 2'd0, 32'h77);
        alu_wren = 1'b1; alu_addr = 5'd1; alu_data = 32'h1; lsu_en = 1'b1;
        step(); step();
        alu_wren = 1'b0; lsu_en = 1'b0; rst_n = 1'b0;
        step();
        check("rst_wren", {31'd0, rd_wren}, 32'd0);
        check("rst_mask", busy_mask, 32'd0);
        check("rst_ready", {31'd0, lsu_ready}, 32'd0);
        rst_n = 1'b1;
        wlog.delete();
        for (int i = 0; i < 4; i++) idle();
        check("rst_ready_rel", {31'd0, lsu_ready}, 32'd1);
        stale = 1'b0;
        foreach (wlog[i]) if (wlog[i] == 5'd6 || wlog[i] == 5'd7) stale = 1'b1;
        check("rst_stale", {31'd0, stale}, 32'd0);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            if (src.size() < 3 && $urandom_range(0, 2) == 0)
                offer(5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)),
                      2'($urandom_range(0, 3)), $urandom);
            alu_wren = ($urandom_range(0, 2) == 0);
            alu_addr = 5'($urandom_range(0, 31));
            alu_data = $urandom;
            lsu_en   = ($urandom_range(0, 3) != 0);
            rst_n    = ($urandom_range(0, 299) != 0);
            step();
        end
        rst_n = 1'b1;
        lsu_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            alu_wren = 1'b0;
            step();
        end
        check("drain_src", src.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
